// File: rtl/upe_triplediv64uuu.sv
// ---------------------------------------------------------------------------
// upe_triplediv64uuu
//
// Sequential unsigned divider computing Q = floor(N / (B*C)) and
// R = N mod (B*C). It is the inverse of the 16x16x16 triple multiplier.
//
// Operation:
//   1. PASS1 runs a restoring division N / B and yields q1 and r1.
//   2. PASS2 runs a restoring division q1 / C and yields q2 and r2.
//   3. FIXUP recombines the remainders in one cycle: R = r1 + B*r2, Q = q2.
//      R can never exceed B*C-1, so 32 bits always hold it.
// The B*C product is never formed, so no 32-bit divisor datapath is needed.
//
// Parameter:
//   STEPS_PER_CYCLE  quotient bits resolved per clock in each pass.
//                    Legal values are 1, 2 and 4.
//                    Each pass takes 64/STEPS_PER_CYCLE cycles.
//
// Optional build macro:
//   UPE_TRIPLEDIV_PROBE_EN
//     Defined:   probe shows q1 as latched at the end of PASS1.
//                probe is all-ones after a divide-by-zero job.
//     Undefined: probe is tied to zero and no probe register exists.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands valid
//   in_ready     block can accept operands
//   N            64-bit dividend
//   B            first 16-bit divisor
//   C            second 16-bit divisor
//   out_valid    result valid
//   out_ready    consumer accepts result
//   Q            64-bit quotient
//   R            32-bit remainder
//   div_by_zero  B==0 or C==0 for this result
//   probe        debug observation (see the build macro above)
//
// Handshake:
//   Both sides use valid/ready. A transfer happens on a rising edge where
//   valid && ready. The producer holds its payload stable while valid is
//   high and ready is low.
//   On the input side, in_ready is high only in IDLE, so exactly one job is
//   in flight at a time.
//   On the output side, out_valid is high only in DONE. Q, R and
//   div_by_zero stay stable until the transfer.
//   No operand is accepted in the same cycle as a result transfer.
//
// Debug:
//   state_q is a typed enum register so checkers can bind to the FSM state.
// ---------------------------------------------------------------------------
module upe_triplediv64uuu #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] N,
  input  logic [15:0] B,
  input  logic [15:0] C,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] Q,
  output logic [31:0] R,
  output logic        div_by_zero,
  output logic [63:0] probe
);

  localparam int         PASS_CYCLES = 64 / STEPS_PER_CYCLE;
  localparam logic [5:0] LAST_CNT    = 6'(PASS_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PASS1 = 3'd1,
    S_PASS2 = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;

  // acc_q holds the dividend as it shifts out MSB-first.
  // Quotient bits shift into its LSB end as they are resolved.
  logic [63:0] acc_q, acc_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] b_q, b_d;
  logic [15:0] c_q, c_d;
  logic [15:0] r1_q, r1_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        dbz_q, dbz_d;

  logic        accept;
  logic        zero_in;
  logic        last_step;
  logic [15:0] step_div;
  logic [79:0] step_res;
  logic [15:0] step_rem;
  logic [63:0] step_acc;
  logic [31:0] fix_prod;

  // -------------------------------------------------------------------------
  // One cycle of restoring division: STEPS_PER_CYCLE shift/compare/subtract
  // steps. The partial remainder is always below the divisor. The shifted
  // value is therefore below 2*divisor and fits in 17 bits. After a
  // subtraction the remainder fits in 16 bits again.
  // -------------------------------------------------------------------------
  function automatic logic [79:0] div_steps(input logic [15:0] rem_in,
                                            input logic [63:0] acc_in,
                                            input logic [15:0] dv);
    logic [16:0] t;
    logic [15:0] r;
    logic [63:0] a;
    r = rem_in;
    a = acc_in;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      t = {r, a[63]};
      a = {a[62:0], 1'b0};
      if (t >= {1'b0, dv}) begin
        t    = t - {1'b0, dv};
        a[0] = 1'b1;
      end
      r = t[15:0];
    end
    return {r, a};
  endfunction

  assign accept    = in_valid && in_ready;
  assign zero_in   = (B == 16'h0) || (C == 16'h0);
  assign last_step = (cnt_q == LAST_CNT);
  assign step_div  = (state_q == S_PASS1) ? b_q : c_q;
  assign step_res  = div_steps(rem_q, acc_q, step_div);
  assign step_rem  = step_res[79:64];
  assign step_acc  = step_res[63:0];

  // 16x16 multiply for the remainder fix-up (B * r2).
  assign fix_prod  = 32'(b_q) * 32'(rem_q);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = zero_in ? S_DONE : S_PASS1;
      S_PASS1: if (last_step) state_d = S_PASS2;
      S_PASS2: if (last_step) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Datapath next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    b_d   = b_q;
    c_d   = c_q;
    r1_d  = r1_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    r_d   = r_q;
    dbz_d = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          b_d   = B;
          c_d   = C;
          acc_d = N;
          rem_d = 16'h0;
          r1_d  = 16'h0;
          cnt_d = 6'h0;
          // A zero divisor skips both passes; the result is produced here.
          if (zero_in) begin
            q_d   = '1;
            r_d   = 32'h0;
            dbz_d = 1'b1;
          end
        end
      end
      S_PASS1: begin
        acc_d = step_acc;
        rem_d = step_rem;
        cnt_d = cnt_q + 6'd1;
        if (last_step) begin
          // acc now holds q1, which becomes the dividend of PASS2.
          // Park r1 and restart the partial remainder.
          r1_d  = step_rem;
          rem_d = 16'h0;
          cnt_d = 6'h0;
        end
      end
      S_PASS2: begin
        acc_d = step_acc;
        rem_d = step_rem;
        cnt_d = cnt_q + 6'd1;
        if (last_step) cnt_d = 6'h0;
      end
      S_FIXUP: begin
        // N = B*q1 + r1 and q1 = C*q2 + r2.
        // Together they give N = B*C*q2 + (B*r2 + r1).
        q_d   = acc_q;
        r_d   = {16'h0, r1_q} + fix_prod;
        dbz_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= 64'h0;
      rem_q <= 16'h0;
      b_q   <= 16'h0;
      c_q   <= 16'h0;
      r1_q  <= 16'h0;
      cnt_q <= 6'h0;
      q_q   <= 64'h0;
      r_q   <= 32'h0;
      dbz_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      rem_q <= rem_d;
      b_q   <= b_d;
      c_q   <= c_d;
      r1_q  <= r1_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dbz_q <= dbz_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign div_by_zero = dbz_q;

  // -------------------------------------------------------------------------
  // Optional debug probe
  // -------------------------------------------------------------------------
`ifdef UPE_TRIPLEDIV_PROBE_EN
  logic [63:0] probe_q, probe_d;

  always_comb begin
    probe_d = probe_q;
    if (state_q == S_IDLE && accept && zero_in) probe_d = '1;
    else if (state_q == S_PASS1 && last_step)   probe_d = step_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) probe_q <= 64'h0;
    else        probe_q <= probe_d;
  end

  assign probe = probe_q;
`else
  assign probe = 64'h0;
`endif

endmodule

// File: doc/upe_triplediv64uuu.md
Name: upe_triplediv64uuu

Overview:
- Sequential unsigned divider; the inverse of the 16x16x16 triple multiplier.
- Takes a 64-bit dividend N and two 16-bit divisors B and C.
- Returns Q = floor(N / (B*C)) (64-bit) and R = N mod (B*C) (32-bit).
- Implemented as two chained restoring-division passes followed by a remainder fix-up using the existing 16x16 unsigned multiplier; valid/ready handshake on both sides.

Parameters:
- STEPS_PER_CYCLE, 1: quotient bits resolved per clock in each pass. Legal values 1, 2, 4. Pass length is 64/STEPS_PER_CYCLE cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- N  input  64  dividend
- B  input  16  first divisor
- C  input  16  second divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Q  output  64  quotient
- R  output  32  remainder
- div_by_zero  output  1  B==0 or C==0 for this result
- probe  output  64  debug observation, see Optional Feature

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE.
  - in_ready=1, out_valid=0, Q=0, R=0, div_by_zero=0, probe=0.
  - All internal registers cleared.
  - Reset mid-operation abandons the job; no result is ever presented for it.
- Accept:
  - Transfer on a rising edge with in_valid&&in_ready.
  - N, B, C are latched; in_ready drops the following cycle.
  - Inputs are ignored while in_ready=0.
- States: IDLE -> PASS1 -> PASS2 -> FIXUP -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On accept with B!=0 and C!=0: go to PASS1.
  - On accept with B==0 or C==0: go directly to DONE with Q=64'hFFFF_FFFF_FFFF_FFFF, R=0, div_by_zero=1.
- PASS1:
  - Restoring division N/B, STEPS_PER_CYCLE quotient bits per cycle, MSB first.
  - Produces q1 (64b) and r1 (16b) after 64/STEPS_PER_CYCLE cycles.
- PASS2:
  - Restoring division q1/C, same length.
  - Produces q2 (64b) and r2 (16b).
- FIXUP (one cycle):
  - R = r1 + B*r2, computed with a 16x16 multiplier plus a 32-bit add; Q = q2.
  - Cannot overflow: maximum is B*C-1 < 2^32.
- DONE:
  - out_valid=1; Q, R and div_by_zero held stable until out_valid&&out_ready.
  - On that edge: out_valid=0, in_ready=1, return to IDLE.
  - No new operand is accepted in the same cycle as the result transfer.
- Latency, accept edge to out_valid high:
  - Normal case: 2*(64/STEPS_PER_CYCLE)+2 cycles (130 for the default).
  - Divide-by-zero: 1 cycle.
- Q, R and div_by_zero retain their last values after transfer until overwritten by the next result.
- Only one operation is in flight at a time; there is no pipelining.

Optional Feature:
- Macro UPE_TRIPLEDIV_PROBE_EN.
- Defined:
  - probe = q1 latched at the end of PASS1.
  - probe is held until the next accept, is 0 on reset, and is all-ones on a divide-by-zero job.
- Undefined:
  - probe is tied to 64'h0 and no extra registers are synthesized.
- Q, R, latency and handshake are identical in both builds.

Test Plan:
- Exact round-trip: N=462, B=7, C=11 -> Q=6, R=0, div_by_zero=0, out_valid exactly 130 cycles after accept (STEPS_PER_CYCLE=1); probe=66 when UPE_TRIPLEDIV_PROBE_EN is defined.
- Remainder: N=1000, B=7, C=11 -> Q=12, R=76 (internally r1=6, q1=142, r2=10).
- Max multiplier round-trip: N=0xFFFF*0xFFFF*0xFFFF=64'h0000_FFFD_0002_FFFF, B=C=16'hFFFF -> Q=16'hFFFF zero-extended to 64 bits, R=0.
  - Repeat the whole suite with STEPS_PER_CYCLE=4; latency must be 34.
- Divide-by-zero: N=123, B=0, C=5 -> out_valid 1 cycle after accept, Q=64'hFFFF_FFFF_FFFF_FFFF, R=0, div_by_zero=1.
  - Next job N=10, B=1, C=2 -> Q=5, R=0, div_by_zero=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> Q and R stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> in_ready=1 on the next cycle.
- Reset mid-PASS2: assert rst_n=0 asynchronously -> all outputs 0 and in_ready=1 immediately; after release, the job N=77, B=7, C=11 completes with Q=1, R=0.
